// File: rtl/reg_status_file_if.sv
// Dispatcher/ROB-facing bus of the rename-tracking register file.
// The master side is the core (dispatcher reads/allocs, ROB commits/rollback);
// the slave side is reg_status_file.
interface reg_status_file_if #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_RD   = 2
);
    localparam int RW = $clog2(NUM_REGS);

    logic                    rdy;
    logic [NUM_RD*RW-1:0]    rd_idx;
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_RD*TAG_W-1:0] rd_tag;
    logic [NUM_RD*XLEN-1:0]  rd_val;
    logic                    alloc_en;
    logic [RW-1:0]           alloc_rd;
    logic [TAG_W-1:0]        alloc_tag;
    logic                    commit_en;
    logic [RW-1:0]           commit_rd;
    logic [TAG_W-1:0]        commit_tag;
    logic [XLEN-1:0]         commit_val;
    logic                    rollback;

    modport master (
        output rdy, rd_idx, alloc_en, alloc_rd, alloc_tag,
               commit_en, commit_rd, commit_tag, commit_val, rollback,
        input  rd_busy, rd_tag, rd_val
    );

    modport slave (
        input  rdy, rd_idx, alloc_en, alloc_rd, alloc_tag,
               commit_en, commit_rd, commit_tag, commit_val, rollback,
        output rd_busy, rd_tag, rd_val
    );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy/tag rename tracking.
// Register 0 is hard zero: it is never written, so its reset value persists.
module reg_status_file #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_RD   = 2
) (
    input logic               clk,
    input logic               rst_n,
    reg_status_file_if.slave  bus
);
    localparam int RW = $clog2(NUM_REGS);

    logic [XLEN-1:0]     val_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;

    logic [NUM_RD-1:0]       busy_o;
    logic [NUM_RD*TAG_W-1:0] tag_o;
    logic [NUM_RD*XLEN-1:0]  val_o;

    logic commit_ok;
    logic alloc_ok;

    assign commit_ok = bus.commit_en && (bus.commit_rd != '0);
    assign alloc_ok  = bus.alloc_en && (bus.alloc_rd != '0) && !bus.rollback;

    // Read ports: stored state, or the retiring value when the commit
    // resolves exactly the rename the source is waiting on.
    always_comb begin
        busy_o = '0;
        tag_o  = '0;
        val_o  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [RW-1:0] idx;
            idx = bus.rd_idx[k*RW +: RW];
            if (commit_ok && (bus.commit_rd == idx) && busy_q[idx] &&
                (tag_q[idx] == bus.commit_tag)) begin
                busy_o[k]                = 1'b0;
                tag_o[k*TAG_W +: TAG_W]  = tag_q[idx];
                val_o[k*XLEN +: XLEN]    = bus.commit_val;
            end else begin
                busy_o[k]                = busy_q[idx];
                tag_o[k*TAG_W +: TAG_W]  = tag_q[idx];
                val_o[k*XLEN +: XLEN]    = val_q[idx];
            end
        end
    end

    assign bus.rd_busy = busy_o;
    assign bus.rd_tag  = tag_o;
    assign bus.rd_val  = val_o;

    // State update: commit first, then rollback or alloc override busy/tag,
    // so a same-cycle alloc beats the commit's busy clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (bus.rdy) begin
            if (commit_ok) begin
                val_q[bus.commit_rd] <= bus.commit_val;
                if (busy_q[bus.commit_rd] && (tag_q[bus.commit_rd] == bus.commit_tag))
                    busy_q[bus.commit_rd] <= 1'b0;
            end
            if (bus.rollback) begin
                busy_q <= '0;
            end else if (alloc_ok) begin
                busy_q[bus.alloc_rd] <= 1'b1;
                tag_q[bus.alloc_rd]  <= bus.alloc_tag;
            end
        end
    end
endmodule

// File: tb/tb_reg_status_file.sv
// Bench for reg_status_file: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_reg_status_file;
    localparam int NUM_REGS = 32;
    localparam int XLEN     = 32;
    localparam int TAG_W    = 4;
    localparam int NUM_RD   = 2;
    localparam int RW       = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic chk_on = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [XLEN-1:0]  m_val  [NUM_REGS];
    logic             m_busy [NUM_REGS];
    logic [TAG_W-1:0] m_tag  [NUM_REGS];

    reg_status_file_if #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) bus ();

    reg_status_file #(.NUM_REGS(NUM_REGS), .XLEN(XLEN), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input int k, input logic eb, input logic [TAG_W-1:0] et,
                         input logic [XLEN-1:0] ev, input string nm);
        logic ab;
        logic [TAG_W-1:0] at;
        logic [XLEN-1:0] av;
        bit bad;
        ab  = bus.rd_busy[k];
        at  = bus.rd_tag[k*TAG_W +: TAG_W];
        av  = bus.rd_val[k*XLEN +: XLEN];
        bad = (ab !== eb) || (eb && at !== et) || (!eb && av !== ev);
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s port%0d t=%0t: got busy=%b tag=%0h val=%h, expected busy=%b tag=%0h val=%h",
                     nm, k, $time, ab, at, av, eb, et, ev);
        end
    endtask

    // Model update on each rising edge, straight from the ruleset.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
            end
        end else if (bus.rdy) begin
            if (bus.commit_en && bus.commit_rd != 0) begin
                m_val[bus.commit_rd] = bus.commit_val;
                if (m_busy[bus.commit_rd] && m_tag[bus.commit_rd] == bus.commit_tag)
                    m_busy[bus.commit_rd] = 1'b0;
            end
            if (bus.rollback) begin
                for (int i = 0; i < NUM_REGS; i++) m_busy[i] = 1'b0;
            end else if (bus.alloc_en && bus.alloc_rd != 0) begin
                m_busy[bus.alloc_rd] = 1'b1;
                m_tag[bus.alloc_rd]  = bus.alloc_tag;
            end
        end
    end

    // Compare every read port against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < NUM_RD; k++) begin
                int r;
                logic eb;
                logic [TAG_W-1:0] et;
                logic [XLEN-1:0] ev;
                r = int'(bus.rd_idx[k*RW +: RW]);
                if (bus.commit_en && r != 0 && int'(bus.commit_rd) == r &&
                    m_busy[r] && m_tag[r] == bus.commit_tag) begin
                    eb = 1'b0; et = '0; ev = bus.commit_val;
                end else begin
                    eb = m_busy[r]; et = m_tag[r]; ev = m_val[r];
                end
                check(k, eb, et, ev, "model");
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rdy = 1'b1; bus.alloc_en = 1'b0; bus.commit_en = 1'b0; bus.rollback = 1'b0;
    endtask

    task automatic set_rd(input int a, input int b);
        logic [RW-1:0] ra, rb;
        ra = RW'(a); rb = RW'(b);
        bus.rd_idx = {rb, ra};
    endtask

    task automatic alloc(input int r, input int t);
        bus.alloc_en = 1'b1; bus.alloc_rd = RW'(r); bus.alloc_tag = TAG_W'(t);
    endtask

    task automatic commit(input int r, input int t, input logic [XLEN-1:0] v);
        bus.commit_en = 1'b1; bus.commit_rd = RW'(r); bus.commit_tag = TAG_W'(t); bus.commit_val = v;
    endtask

    initial begin
        idle();
        bus.rd_idx = '0; bus.alloc_rd = '0; bus.alloc_tag = '0;
        bus.commit_rd = '0; bus.commit_tag = '0; bus.commit_val = '0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        chk_on = 1'b1;

        // reset state and x0 hard zero
        set_rd(5, 0); #2;
        check(0, 0, 0, 32'h0, "rst_x5");
        check(1, 0, 0, 32'h0, "rst_x0");
        commit(0, 0, 32'hDEAD); set_rd(0, 0);
        step(); idle(); #2;
        check(0, 0, 0, 32'h0, "x0_write_ignored");

        // alloc then commit with bypass
        alloc(3, 7); step(); idle(); set_rd(3, 3); #2;
        check(0, 1, 7, 32'h0, "alloc_x3_t7");
        commit(3, 7, 32'h1234); #2;
        check(1, 0, 0, 32'h1234, "bypass_x3");
        step(); idle(); #2;
        check(0, 0, 0, 32'h1234, "stored_x3");

        // older commit must not clear a younger rename
        alloc(3, 2); step(); alloc(3, 5); step(); idle();
        commit(3, 2, 32'hAA); step(); idle(); #2;
        check(0, 1, 5, 32'h0, "younger_rename_kept");
        commit(3, 5, 32'hBB); step(); idle(); #2;
        check(0, 0, 0, 32'hBB, "younger_commit");

        // commit+alloc same register: bypass read, alloc wins
        alloc(4, 1); step(); idle();
        commit(4, 1, 32'h11); alloc(4, 6); set_rd(4, 4); #2;
        check(0, 0, 0, 32'h11, "bypass_x4");
        step(); idle(); #2;
        check(1, 1, 6, 32'h0, "alloc_wins_x4");

        // rollback with same-cycle commit and dropped alloc
        alloc(1, 1); step(); alloc(2, 2); step(); alloc(3, 3); step(); idle();
        bus.rollback = 1'b1; commit(9, 0, 32'h99); alloc(10, 4);
        step(); idle();
        set_rd(1, 2); #2;
        check(0, 0, 0, m_val[1], "rb_x1");
        check(1, 0, 0, m_val[2], "rb_x2");
        set_rd(3, 10); #2;
        check(0, 0, 0, 32'hBB, "rb_x3");
        check(1, 0, 0, 32'h0, "rb_x10");
        set_rd(9, 9); #2;
        check(0, 0, 0, 32'h99, "rb_x9");

        // rdy low ignores alloc
        bus.rdy = 1'b0; alloc(7, 3); step(); idle(); set_rd(7, 7); #2;
        check(0, 0, 0, 32'h0, "rdy_low_x7");

        // commits then reset (with pending alloc/commit) clear everything
        for (int i = 5; i < 9; i++) begin
            commit(i, 0, 32'h100 + i); step();
        end
        idle(); alloc(12, 9); commit(13, 0, 32'h55); rst_n = 1'b0;
        step(); idle(); rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i += 2) begin
            set_rd(i, i + 1); #1;
            check(0, 0, 0, 32'h0, "post_rst_even");
            check(1, 0, 0, 32'h0, "post_rst_odd");
        end

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            bus.rdy        = ($urandom_range(0, 9) != 0);
            bus.rd_idx     = {RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7))};
            bus.alloc_en   = ($urandom_range(0, 2) == 0);
            bus.alloc_rd   = RW'($urandom_range(0, 7));
            bus.alloc_tag  = TAG_W'($urandom_range(0, 3));
            bus.commit_en  = ($urandom_range(0, 1) == 0);
            bus.commit_rd  = RW'($urandom_range(0, 7));
            bus.commit_tag = TAG_W'($urandom_range(0, 3));
            bus.commit_val = $urandom;
            bus.rollback   = ($urandom_range(0, 29) == 0);
            rst_n          = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1; idle();
        step();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_status_file.md
# reg_status_file

Parametrised architectural register file with rename-tag tracking for the out-of-order core. It sits between the dispatcher, which reads source operands and allocates destination tags, and the ROB, which commits results and signals rollback. It has N dispatcher read ports, an explicit busy bit per register, and same-cycle commit bypass. All state updates are clocked.

## Interface
- NUM_REGS, 32: architectural registers; index width RW = clog2(NUM_REGS).
- XLEN, 32: data width.
- TAG_W, 4: ROB id width.
- NUM_RD, 2: dispatcher read ports; must be at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rdy  in  1  global enable; when low, state is frozen and reads stay live.
- rd_idx  in  NUM_RD*RW  packed source register indices; port k is bits [k*RW +: RW].
- rd_busy  out  NUM_RD  1 means the source is pending on a tag.
- rd_tag  out  NUM_RD*TAG_W  pending ROB id; valid only when busy.
- rd_val  out  NUM_RD*XLEN  register value; valid only when not busy.
- alloc_en  in  1  dispatcher is renaming a destination this cycle.
- alloc_rd  in  RW  destination register.
- alloc_tag  in  TAG_W  ROB id assigned to the destination.
- commit_en  in  1  ROB is retiring an instruction this cycle.
- commit_rd  in  RW  retiring destination register.
- commit_tag  in  TAG_W  ROB id of the retiring instruction.
- commit_val  in  XLEN  retiring result.
- rollback  in  1  flush all renames.

## Operation
- Per register state: val[XLEN], busy, tag[TAG_W].
- Register 0 always reads val=0 and busy=0. Writes and allocations to register 0 are ignored.
- Read port k is combinational from the current state plus bypass:
  - if commit_en, commit_rd == rd_idx[k] != 0, busy[r] is set and tag[r] == commit_tag: outputs are busy=0 and val=commit_val;
  - otherwise outputs are the stored val, busy and tag.
- The same-cycle alloc is not visible to reads. Sources read the state from before this instruction's own destination rename.
- Commit, on the rising edge when rdy && commit_en && commit_rd != 0:
  - val[commit_rd] <= commit_val unconditionally;
  - busy is cleared only if busy is set and tag == commit_tag. A younger rename of the same register keeps busy set.
- Alloc, on the rising edge when rdy && alloc_en && alloc_rd != 0 && !rollback: busy <= 1 and tag <= alloc_tag.
- If commit and alloc target the same register in one cycle, alloc wins: busy=1, tag=alloc_tag, and val is still updated by the commit.
- Rollback, on the rising edge when rdy && rollback: every busy bit is cleared and tags are left as-is. The commit in the same cycle still writes its val, and alloc is dropped.
- Debug output is not provided. The state is observable only through the read ports.

## Timing
- Reads have zero latency (combinational). State changes take effect on the edge after the request is sampled.
- Reset: when rst_n is low at a rising edge, all val=0, busy=0 and tag=0. This has priority over rdy and every other input.
  - Read outputs after reset are busy=0, val=0 and tag=0 for every index.
- Reset asserted in the middle of activity discards any pending alloc or commit in that cycle.
- When rdy is low, alloc, commit and rollback are ignored (not queued). The read bypass still applies combinationally, but the caller must not rely on it while rdy is low.
- Multiple read ports addressing the same register return identical results.
- The bypass compare uses the pre-edge state only. The result never depends on another port or on alloc.

## Test plan
- Reset, then read x5 and x0 on both ports: busy=0, val=0. Commit x0 with 0xDEAD, then read x0: val=0, busy=0.
- Alloc x3 with tag 7. Next cycle read x3: busy=1, tag=7. Commit x3 with tag 7 and value 0x1234; during that cycle read x3: busy=0, val=0x1234. Next cycle the stored state is the same.
- Alloc x3 with tag 2, then alloc x3 with tag 5, then commit x3 with tag 2 and value 0xAA: val=0xAA, busy=1, tag=5. Commit with tag 5 and value 0xBB: busy=0, val=0xBB.
- In one cycle, commit x4 with tag 1 and value 0x11, alloc x4 with tag 6, and read x4. The read shows the bypass (val=0x11). Next cycle x4 shows busy=1, tag=6, val=0x11.
- Alloc x1, x2 and x3, then assert rollback together with commit x9 with value 0x99 and alloc x10. Next cycle: x1, x2, x3 and x10 are not busy, and x9 has val=0x99.
- With rdy=0, alloc x7 with tag 3: x7 stays not busy. Then rst_n=0 for one edge after several commits: every register reads 0 and not busy.
